// File: rtl/sap_alu.sv
// SAP-style accumulator ALU: A/B operand registers, half-adder ripple add/subtract, registered bus driver.
// Optional flag registers (cf/zf) are built only when SAP_ALU_FLAGS_EN is defined.
module sap_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             la,
    input  logic             lb,
    input  logic             su,
    input  logic             eu,
    input  logic             ea,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic [WIDTH-1:0] a_q
`ifdef SAP_ALU_FLAGS_EN
    ,
    output logic             cf,
    output logic             zf
`endif
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_bus_out;
    logic [WIDTH-1:0] w_bus_out_nxt;
    logic [WIDTH-1:0] w_b_op;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_c;

    // Subtract is A + ~B + 1: invert B and inject the +1 as carry-in.
    assign w_b_op = su ? ~r_b : r_b;
    assign w_c[0] = su;

    // Each bit is two half-adder cells whose carries are ORed into the ripple chain.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        logic w_h1_s;
        logic w_h1_c;
        logic w_h2_c;
        assign w_h1_s   = r_a[i] ^ w_b_op[i];
        assign w_h1_c   = r_a[i] & w_b_op[i];
        assign w_sum[i] = w_h1_s ^ w_c[i];
        assign w_h2_c   = w_h1_s & w_c[i];
        assign w_c[i+1] = w_h1_c | w_h2_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            if (la) r_a <= bus_in;
            if (lb) r_b <= bus_in;
        end
    end

    // Output-stage state register; bus_out is captured alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bus_out <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bus_out <= w_bus_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        if (eu || ea) w_state_nxt = S_DRIVE;
    end

    // eu wins over ea; operands are the pre-load values, giving read-before-write.
    always_comb begin
        w_bus_out_nxt = '0;
        if (eu)      w_bus_out_nxt = w_sum;
        else if (ea) w_bus_out_nxt = r_a;
    end

    assign bus_out = r_bus_out;
    assign bus_oe  = (r_state == S_DRIVE);
    assign a_q     = r_a;

`ifdef SAP_ALU_FLAGS_EN
    logic r_cf;
    logic r_zf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cf <= 1'b0;
            r_zf <= 1'b0;
        end else if (eu) begin
            r_cf <= w_c[WIDTH];
            r_zf <= (w_sum == '0);
        end
    end

    assign cf = r_cf;
    assign zf = r_zf;
`else
    logic w_unused_cout;
    assign w_unused_cout = w_c[WIDTH];
`endif

endmodule

// File: tb/tb_sap_alu.sv
// Scoreboard bench for sap_alu: expectations queued as stimulus is driven, popped after each edge.
module tb_sap_alu;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] bus_in;
    logic         la, lb, su, eu, ea;
    logic [W-1:0] bus_out;
    logic         bus_oe;
    logic [W-1:0] a_q;
`ifdef SAP_ALU_FLAGS_EN
    logic         cf, zf;
`endif

    always #5 clk = ~clk;

    sap_alu #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus_in  (bus_in),
        .la      (la),
        .lb      (lb),
        .su      (su),
        .eu      (eu),
        .ea      (ea),
        .bus_out (bus_out),
        .bus_oe  (bus_oe),
        .a_q     (a_q)
`ifdef SAP_ALU_FLAGS_EN
        ,
        .cf      (cf),
        .zf      (zf)
`endif
    );

    typedef struct packed {
        logic         oe;
        logic [W-1:0] out;
        logic [W-1:0] aq;
        logic         cf;
        logic         zf;
    } exp_t;

    exp_t         sb[$];
    exp_t         e;
    logic [W-1:0] m_a, m_b;
    logic         m_cf, m_zf;
    int           n_tests = 0;
    int           n_fail  = 0;

    // Drive one cycle of inputs, queue the model's prediction, and step past the edge.
    task automatic step(input logic rst, input logic [W-1:0] din, input logic la_i, input logic lb_i,
                        input logic su_i, input logic eu_i, input logic ea_i);
        exp_t       x;
        logic [W:0] r;
        rst_n = rst; bus_in = din; la = la_i; lb = lb_i; su = su_i; eu = eu_i; ea = ea_i;
        if (su_i) r = {1'b0, m_a} - {1'b0, m_b} + (W+1)'(1 << W);
        else      r = {1'b0, m_a} + {1'b0, m_b};
        x = '0;
        if (!rst) begin
            m_a = '0; m_b = '0; m_cf = 1'b0; m_zf = 1'b0;
        end else begin
            if (eu_i) begin
                x.oe = 1'b1; x.out = r[W-1:0];
                m_cf = r[W]; m_zf = (r[W-1:0] == '0);
            end else if (ea_i) begin
                x.oe = 1'b1; x.out = m_a;
            end
            if (la_i) m_a = din;
            if (lb_i) m_b = din;
        end
        x.aq = m_a; x.cf = m_cf; x.zf = m_zf;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        m_a = 'x; m_b = 'x;
        step(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        e = sb.pop_front();
        n_tests++;
        if (bus_oe !== 1'b0 || bus_out !== 8'h00 || a_q !== 8'h00 || e.oe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: oe/out/a_q=%b/%h/%h want 0/00/00", bus_oe, bus_out, a_q);
        end
`ifdef SAP_ALU_FLAGS_EN
        n_tests++;
        if (cf !== 1'b0 || zf !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: cf/zf=%b/%b want 0/0", cf, zf);
        end
`endif
    endtask

    // Directed add/subtract/wrap sequence with spec-given result checks.
    task automatic test_add_sub();
        logic [W-1:0] want[12];
        logic [4:0]   st[12];
        logic [W-1:0] din[12];
        // st = {la, lb, su, eu, ea}
        st = '{5'b10000, 5'b01000, 5'b00010, 5'b11000, 5'b00110, 5'b10000, 5'b01000,
               5'b00110, 5'b11000, 5'b01000, 5'b00010, 5'b00000};
        din = '{8'h05, 8'h03, 8'h00, 8'h05, 8'h00, 8'h03, 8'h05, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h00};
        want = '{8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 12; i++) begin
            step(1'b1, din[i], st[i][4], st[i][3], st[i][2], st[i][1], st[i][0]);
            e = sb.pop_front();
            n_tests++;
            if (bus_oe !== e.oe || bus_out !== e.out || a_q !== e.aq || bus_out !== want[i]) begin
                n_fail++;
                $display("FAIL add_sub[%0d]: oe/out/a_q=%b/%h/%h want %b/%h/%h", i, bus_oe, bus_out, a_q,
                         e.oe, e.out, e.aq);
            end
`ifdef SAP_ALU_FLAGS_EN
            n_tests++;
            if (cf !== e.cf || zf !== e.zf) begin
                n_fail++; $display("FAIL add_sub_flags[%0d]: cf/zf=%b/%b want %b/%b", i, cf, zf, e.cf, e.zf);
            end
`endif
        end
`ifdef SAP_ALU_FLAGS_EN
        // 0xFF+0x01 wrapped, then an idle cycle: flags must still read cf=1 zf=1.
        n_tests++;
        if (cf !== 1'b1 || zf !== 1'b1 || bus_oe !== 1'b0) begin
            n_fail++; $display("FAIL wrap_hold: cf/zf/oe=%b/%b/%b want 1/1/0", cf, zf, bus_oe);
        end
`endif
    endtask

    // Load coincident with eu, then eu/ea priority and ea alone.
    task automatic test_rbw_priority();
        logic [W-1:0] want[9];
        logic [4:0]   st[9];
        logic [W-1:0] din[9];
        st = '{5'b10000, 5'b01000, 5'b10010, 5'b00010, 5'b10000, 5'b01000, 5'b00011, 5'b00001, 5'b00000};
        din = '{8'h10, 8'h01, 8'h20, 8'h00, 8'h07, 8'h02, 8'h00, 8'h00, 8'h00};
        want = '{8'h00, 8'h00, 8'h11, 8'h21, 8'h00, 8'h00, 8'h09, 8'h07, 8'h00};
        for (int i = 0; i < 9; i++) begin
            step(1'b1, din[i], st[i][4], st[i][3], st[i][2], st[i][1], st[i][0]);
            e = sb.pop_front();
            n_tests++;
            if (bus_oe !== e.oe || bus_out !== e.out || a_q !== e.aq || bus_out !== want[i]) begin
                n_fail++;
                $display("FAIL rbw_prio[%0d]: oe/out/a_q=%b/%h/%h want %b/%h/%h", i, bus_oe, bus_out, a_q,
                         e.oe, e.out, e.aq);
            end
            if (i == 2) begin
                n_tests++;
                if (a_q !== 8'h20) begin
                    n_fail++; $display("FAIL rbw_a_q: a_q=%h want 20", a_q);
                end
            end
        end
    endtask

    // Reset asserted mid-DRIVE with eu still high must win.
    task automatic test_reset_in_drive();
        step(1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (bus_oe !== 1'b1 || bus_out !== 8'h0A) begin
            n_fail++; $display("FAIL pre_reset_drive: oe/out=%b/%h want 1/0a", bus_oe, bus_out);
        end
        step(1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        e = sb.pop_front();
        n_tests++;
        if (bus_oe !== 1'b0 || bus_out !== 8'h00 || a_q !== 8'h00 || e.oe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_drive: oe/out/a_q=%b/%h/%h want 0/00/00", bus_oe, bus_out, a_q);
        end
`ifdef SAP_ALU_FLAGS_EN
        n_tests++;
        if (cf !== 1'b0 || zf !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_drive_flags: cf/zf=%b/%b want 0/0", cf, zf);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) != 0), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
            e = sb.pop_front();
            n_tests++;
            if (bus_oe !== e.oe || bus_out !== e.out || a_q !== e.aq) begin
                n_fail++;
                $display("FAIL random[%0d]: oe/out/a_q=%b/%h/%h want %b/%h/%h", i, bus_oe, bus_out, a_q,
                         e.oe, e.out, e.aq);
            end
`ifdef SAP_ALU_FLAGS_EN
            n_tests++;
            if (cf !== e.cf || zf !== e.zf) begin
                n_fail++; $display("FAIL random_flags[%0d]: cf/zf=%b/%b want %b/%b", i, cf, zf, e.cf, e.zf);
            end
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0; bus_in = '0; la = 1'b0; lb = 1'b0; su = 1'b0; eu = 1'b0; ea = 1'b0;
        m_cf = 1'b0; m_zf = 1'b0;
        test_reset();
        test_add_sub();
        test_rbw_priority();
        test_reset_in_drive();
        test_random();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sap_alu.md
SAP_ALU -- requirements
Module: sap_alu

Interface
REQ-001 Parameter: WIDTH, default 8, data width of the A, B and result paths; legal range 4..16.
REQ-002 clk  input  1  single rising-edge system clock.
REQ-003 rst_n  input  1  reset, synchronous, active-low, sampled on rising clk edge.
REQ-004 bus_in  input  WIDTH  shared data bus value presented for register loads.
REQ-005 la  input  1  load A register from bus_in at the next rising edge.
REQ-006 lb  input  1  load B register from bus_in at the next rising edge.
REQ-007 su  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-008 eu  input  1  drive the ALU result onto bus_out and capture flags.
REQ-009 ea  input  1  drive the A register onto bus_out.
REQ-010 bus_out  output  WIDTH  registered data driven to the shared bus.
REQ-011 bus_oe  output  1  registered; 1 when bus_out carries valid data.
REQ-012 a_q  output  WIDTH  current A register contents (monitor).
REQ-013 cf  output  1  registered carry flag (present only with SAP_ALU_FLAGS_EN).
REQ-014 zf  output  1  registered zero flag (present only with SAP_ALU_FLAGS_EN).

Function
REQ-015 Result SHALL be computed from registered A and B by a ripple chain of half-adder cells: add = A+B; subtract = A + ~B + 1 (two's complement), truncated to WIDTH bits.
REQ-016 Carry-out SHALL be the carry from bit WIDTH-1; in subtract mode carry-out 1 means no borrow (A >= B unsigned).
REQ-017 la=1 at a rising edge SHALL load A <= bus_in; lb=1 SHALL load B <= bus_in; both set loads both with the same value.
REQ-018 Output stage is a registered two-state FSM: IDLE (bus_oe=0) and DRIVE (bus_oe=1); each edge with eu|ea=1 enters/stays in DRIVE, otherwise returns to IDLE.
REQ-019 Latency: eu sampled at edge N SHALL present the result of A/B values held before edge N on bus_out after edge N (one cycle); same for ea with A.
REQ-020 eu and ea both 1: eu SHALL have priority; bus_out = result.
REQ-021 la/lb coincident with eu/ea: read-before-write; bus_out uses the pre-load A/B values, registers update at the same edge.
REQ-022 In IDLE bus_out SHALL be all zeros.
REQ-023 Flags SHALL update only on edges where eu=1: cf <= carry-out, zf <= (result == 0); otherwise flags hold.
REQ-024 su SHALL be sampled on the same edge as eu; su with eu=0 has no effect.

Reset
REQ-025 With rst_n=0 at a rising edge: A, B, bus_out, a_q = 0; bus_oe = 0; FSM = IDLE; cf = zf = 0.
REQ-026 Reset SHALL dominate la, lb, eu, ea in the same cycle; an in-progress DRIVE is abandoned and bus_oe drops after that edge.
REQ-027 No output SHALL be X after the first reset edge.

Configuration
REQ-028 Macro SAP_ALU_FLAGS_EN: when defined, cf/zf ports and flag registers exist per REQ-023.
REQ-029 When SAP_ALU_FLAGS_EN is undefined, cf/zf ports and flag logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset, load A=0x05, B=0x03, eu=1 su=0 -> next cycle bus_out=0x08, bus_oe=1, cf=0, zf=0.
REQ-031 A=0x05, B=0x05, eu=1 su=1 -> bus_out=0x00, cf=1, zf=1; A=0x03, B=0x05 subtract -> bus_out=0xFE, cf=0, zf=0.
REQ-032 A=0xFF, B=0x01, add -> bus_out=0x00, cf=1, zf=1; following cycle eu=0 -> bus_oe=0, bus_out=0x00, flags hold cf=1 zf=1.
REQ-033 A=0x10, B=0x01, same edge la=1 bus_in=0x20 and eu=1 -> bus_out=0x11, a_q=0x20; next eu -> bus_out=0x21.
REQ-034 eu=1 and ea=1 together with A=0x07, B=0x02 -> bus_out=0x09; ea alone -> bus_out=0x07.
REQ-035 rst_n=0 while eu=1 in DRIVE -> next edge bus_oe=0, bus_out=0x00, a_q=0x00, cf=zf=0; repeat REQ-030 without SAP_ALU_FLAGS_EN -> identical bus_out, no flag ports.
